// File: rtl/game_renderer.sv
// ---------------------------------------------------------------------------
// game_renderer
//   Consumer side of the game-state interface. Once per frame it snapshots the
//   physics outputs and pulses START_UPDATE so physics can advance. Per pixel
//   it produces an 8-bit colour {R[2:0],G[2:0],B[1:0]} through a fixed
//   3-stage pipeline (geometry -> hit tests -> priority mux).
//
// Ports
//   CLK, RESET_N          pixel clock, asynchronous active-low reset
//   PIXEL_X/Y, PIXEL_VALID beam position and visible-area flag
//   FRAME_START           one-cycle pulse at start of vertical blanking
//   PADDLE_X_PIXEL        paddle left edge          (physics)
//   BALL_X/Y_PIXEL        ball top-left corner      (physics)
//   BLOCK_STATE           1 = block present, index row*BLOCK_COLS+col
//   BALL_LOST             ball lost flag            (physics)
//   START_UPDATE          one-cycle pulse to physics after each snapshot
//   COLOR, COLOR_VALID    pixel colour, 3 cycles after the pixel inputs
// ---------------------------------------------------------------------------
module game_renderer #(
  parameter int unsigned BLOCK_START_X    = 16,
  parameter int unsigned BLOCK_START_Y    = 64,
  parameter int unsigned BLOCK_COLS       = 12,
  parameter int unsigned BLOCK_ROWS       = 6,
  parameter int unsigned WALL_LEFT_END    = 16,
  parameter int unsigned WALL_RIGHT_BEGIN = 784,
  parameter int unsigned CEILING_END      = 16,
  parameter int unsigned PADDLE_Y         = 560,
  parameter int unsigned PADDLE_LEN       = 64,
  parameter int unsigned BALL_SIZE        = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [9:0]  PIXEL_X,
  input  logic [9:0]  PIXEL_Y,
  input  logic        PIXEL_VALID,
  input  logic        FRAME_START,
  input  logic [9:0]  PADDLE_X_PIXEL,
  input  logic [9:0]  BALL_X_PIXEL,
  input  logic [9:0]  BALL_Y_PIXEL,
  input  logic [71:0] BLOCK_STATE,
  input  logic        BALL_LOST,
  output logic        START_UPDATE,
  output logic [7:0]  COLOR,
  output logic        COLOR_VALID
);

  localparam logic [10:0] GRID_X0    = 11'(BLOCK_START_X);
  localparam logic [10:0] GRID_Y0    = 11'(BLOCK_START_Y);
  localparam logic [10:0] GRID_W     = 11'(BLOCK_COLS * 64);
  localparam logic [10:0] GRID_H     = 11'(BLOCK_ROWS * 16);
  localparam logic [10:0] WALL_L     = 11'(WALL_LEFT_END);
  localparam logic [10:0] WALL_R     = 11'(WALL_RIGHT_BEGIN);
  localparam logic [10:0] CEIL       = 11'(CEILING_END);
  localparam logic [10:0] PAD_TOP    = 11'(PADDLE_Y);
  localparam logic [10:0] PAD_BOT    = 11'(PADDLE_Y + 8);
  localparam logic [10:0] PAD_LEN    = 11'(PADDLE_LEN);
  localparam logic [10:0] BALL_LEN   = 11'(BALL_SIZE);

  // -------------------------------------------------------------------------
  // Snapshot. Inputs are captured into snap_*_q on FRAME_START and copied to
  // the rendering set act_*_q one cycle later, so a pixel presented in the
  // FRAME_START cycle still reaches stage 2 with the previous frame's state.
  // -------------------------------------------------------------------------
  logic        start_update_q;
  logic [9:0]  snap_pad_x_q, snap_ball_x_q, snap_ball_y_q;
  logic [71:0] snap_blocks_q;
  logic        snap_lost_q;
  logic [9:0]  act_pad_x_q, act_ball_x_q, act_ball_y_q;
  logic [71:0] act_blocks_q;
  logic        act_lost_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      start_update_q <= 1'b0;
      snap_pad_x_q   <= '0;
      snap_ball_x_q  <= '0;
      snap_ball_y_q  <= '0;
      snap_blocks_q  <= '0;
      snap_lost_q    <= 1'b0;
      act_pad_x_q    <= '0;
      act_ball_x_q   <= '0;
      act_ball_y_q   <= '0;
      act_blocks_q   <= '0;
      act_lost_q     <= 1'b0;
    end else begin
      start_update_q <= FRAME_START;
      if (FRAME_START) begin
        snap_pad_x_q  <= PADDLE_X_PIXEL;
        snap_ball_x_q <= BALL_X_PIXEL;
        snap_ball_y_q <= BALL_Y_PIXEL;
        snap_blocks_q <= BLOCK_STATE;
        snap_lost_q   <= BALL_LOST;
      end
      if (start_update_q) begin
        act_pad_x_q  <= snap_pad_x_q;
        act_ball_x_q <= snap_ball_x_q;
        act_ball_y_q <= snap_ball_y_q;
        act_blocks_q <= snap_blocks_q;
        act_lost_q   <= snap_lost_q;
      end
    end
  end

  assign START_UPDATE = start_update_q;

  // -------------------------------------------------------------------------
  // Stage 1: grid geometry. Offsets are 11-bit; the explicit x >= origin test
  // keeps an underflowed offset from aliasing back into the grid.
  // -------------------------------------------------------------------------
  logic [10:0] px_w, py_w, dx_d, dy_d;
  logic        in_grid_d, gap_d;
  logic [3:0]  col_d;
  logic [2:0]  row_d;
  logic [6:0]  idx_d;

  assign px_w      = {1'b0, PIXEL_X};
  assign py_w      = {1'b0, PIXEL_Y};
  assign dx_d      = px_w - GRID_X0;
  assign dy_d      = py_w - GRID_Y0;
  assign in_grid_d = (px_w >= GRID_X0) && (dx_d < GRID_W) &&
                     (py_w >= GRID_Y0) && (dy_d < GRID_H);
  assign col_d     = dx_d[9:6];
  assign row_d     = dy_d[6:4];
  assign gap_d     = (dx_d[5:0] == 6'd63) || (dy_d[3:0] == 4'd15);
  assign idx_d     = 7'(32'(row_d) * BLOCK_COLS + 32'(col_d));

  logic [9:0] s1_x_q, s1_y_q;
  logic       s1_valid_q, s1_in_grid_q, s1_gap_q;
  logic [6:0] s1_idx_q;
  logic [2:0] s1_row_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_in_grid_q <= 1'b0;
      s1_gap_q     <= 1'b0;
      s1_idx_q     <= '0;
      s1_row_q     <= '0;
    end else begin
      s1_x_q       <= PIXEL_X;
      s1_y_q       <= PIXEL_Y;
      s1_valid_q   <= PIXEL_VALID;
      s1_in_grid_q <= in_grid_d;
      s1_gap_q     <= gap_d;
      s1_idx_q     <= idx_d;
      s1_row_q     <= row_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: region hit tests against the rendering snapshot.
  // -------------------------------------------------------------------------
  logic [10:0] sx_w, sy_w, bx_w, by_w, padx_w;
  logic        ball_d, paddle_d, block_d, wall_d;
  logic [7:0]  row_color_d;

  assign sx_w   = {1'b0, s1_x_q};
  assign sy_w   = {1'b0, s1_y_q};
  assign bx_w   = {1'b0, act_ball_x_q};
  assign by_w   = {1'b0, act_ball_y_q};
  assign padx_w = {1'b0, act_pad_x_q};

  assign ball_d   = (sx_w >= bx_w) && (sx_w < bx_w + BALL_LEN) &&
                    (sy_w >= by_w) && (sy_w < by_w + BALL_LEN);
  assign paddle_d = (sx_w >= padx_w) && (sx_w < padx_w + PAD_LEN) &&
                    (sy_w >= PAD_TOP) && (sy_w < PAD_BOT);
  assign block_d  = s1_in_grid_q && !s1_gap_q && act_blocks_q[s1_idx_q];
  assign wall_d   = (sx_w < WALL_L) || (sx_w >= WALL_R) || (sy_w < CEIL);

  always_comb begin
    row_color_d = 8'h00;
    case (s1_row_q)
      3'd0:    row_color_d = 8'hE0;
      3'd1:    row_color_d = 8'hF0;
      3'd2:    row_color_d = 8'hFC;
      3'd3:    row_color_d = 8'h1C;
      3'd4:    row_color_d = 8'h03;
      3'd5:    row_color_d = 8'hE3;
      default: row_color_d = 8'h00;
    endcase
  end

  logic       s2_valid_q, s2_ball_q, s2_paddle_q, s2_block_q, s2_wall_q, s2_lost_q;
  logic [7:0] s2_row_color_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_valid_q     <= 1'b0;
      s2_ball_q      <= 1'b0;
      s2_paddle_q    <= 1'b0;
      s2_block_q     <= 1'b0;
      s2_wall_q      <= 1'b0;
      s2_lost_q      <= 1'b0;
      s2_row_color_q <= '0;
    end else begin
      s2_valid_q     <= s1_valid_q;
      s2_ball_q      <= ball_d;
      s2_paddle_q    <= paddle_d;
      s2_block_q     <= block_d;
      s2_wall_q      <= wall_d;
      s2_lost_q      <= act_lost_q;
      s2_row_color_q <= row_color_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: priority mux. Invisible pixels are forced to black.
  // -------------------------------------------------------------------------
  logic [7:0] color_d;
  logic [7:0] color_q;
  logic       color_valid_q;

  always_comb begin
    color_d = 8'h00;
    if (s2_valid_q) begin
      if (s2_ball_q)        color_d = 8'hFF;
      else if (s2_paddle_q) color_d = 8'h1F;
      else if (s2_block_q)  color_d = s2_row_color_q;
      else if (s2_wall_q)   color_d = 8'h92;
      else if (s2_lost_q)   color_d = 8'h40;
      else                  color_d = 8'h00;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      color_q       <= 8'h00;
      color_valid_q <= 1'b0;
    end else begin
      color_q       <= color_d;
      color_valid_q <= s2_valid_q;
    end
  end

  assign COLOR       = color_q;
  assign COLOR_VALID = color_valid_q;

endmodule

// File: tb/tb_game_renderer.sv
// ---------------------------------------------------------------------------
// tb_game_renderer
//   Self-checking bench for game_renderer. One pixel transaction is driven per
//   cycle; its expected colour comes from a behavioural model of the scene and
//   is queued with the cycle it is due on. A negedge monitor pops and compares,
//   and also checks START_UPDATE against the FRAME_START driven a cycle before.
// ---------------------------------------------------------------------------
module tb_game_renderer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [9:0]  PIXEL_X = '0;
  logic [9:0]  PIXEL_Y = '0;
  logic        PIXEL_VALID = 1'b0;
  logic        FRAME_START = 1'b0;
  logic [9:0]  PADDLE_X_PIXEL = '0;
  logic [9:0]  BALL_X_PIXEL = '0;
  logic [9:0]  BALL_Y_PIXEL = '0;
  logic [71:0] BLOCK_STATE = '0;
  logic        BALL_LOST = 1'b0;
  logic        START_UPDATE;
  logic [7:0]  COLOR;
  logic        COLOR_VALID;

  game_renderer dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .PIXEL_X        (PIXEL_X),
    .PIXEL_Y        (PIXEL_Y),
    .PIXEL_VALID    (PIXEL_VALID),
    .FRAME_START    (FRAME_START),
    .PADDLE_X_PIXEL (PADDLE_X_PIXEL),
    .BALL_X_PIXEL   (BALL_X_PIXEL),
    .BALL_Y_PIXEL   (BALL_Y_PIXEL),
    .BLOCK_STATE    (BLOCK_STATE),
    .BALL_LOST      (BALL_LOST),
    .START_UPDATE   (START_UPDATE),
    .COLOR          (COLOR),
    .COLOR_VALID    (COLOR_VALID)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Scene model: the snapshot the DUT should be rendering from.
  int          m_pad = 0, m_bx = 0, m_by = 0;
  logic [71:0] m_blk = '0;
  bit          m_lost = 1'b0;
  logic [7:0]  row_col [6] = '{8'hE0, 8'hF0, 8'hFC, 8'h1C, 8'h03, 8'hE3};

  function automatic logic [7:0] model_color(input int x, input int y);
    int col, row;
    logic [7:0] c;
    c = m_lost ? 8'h40 : 8'h00;
    if (x < 16 || x >= 784 || y < 16) c = 8'h92;
    if (x >= 16 && x < 16 + 12*64 && y >= 64 && y < 64 + 6*16) begin
      col = (x - 16) / 64;
      row = (y - 64) / 16;
      if (m_blk[row*12 + col] && ((x - 16) % 64) != 63 && ((y - 64) % 16) != 15)
        c = row_col[row];
    end
    if (x >= m_pad && x < m_pad + 64 && y >= 560 && y < 568) c = 8'h1F;
    if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) c = 8'hFF;
    return c;
  endfunction

  typedef struct {
    int         due;
    logic       v;
    logic [7:0] c;
    int         x;
    int         y;
  } exp_t;

  exp_t sb[$];
  bit   fs_prev = 1'b0;

  // One transaction per cycle. The expectation uses the model as it stands
  // before this cycle's FRAME_START takes effect.
  task automatic drive(input int x, input int y, input bit v, input bit fs);
    exp_t e;
    @(posedge CLK);
    #1;
    PIXEL_X     = 10'(x);
    PIXEL_Y     = 10'(y);
    PIXEL_VALID = v;
    FRAME_START = fs;
    e.due = cyc + 3;
    e.v   = v;
    e.c   = v ? model_color(x, y) : 8'h00;
    e.x   = x;
    e.y   = y;
    sb.push_back(e);
    if (fs) begin
      m_pad  = int'(PADDLE_X_PIXEL);
      m_bx   = int'(BALL_X_PIXEL);
      m_by   = int'(BALL_Y_PIXEL);
      m_blk  = BLOCK_STATE;
      m_lost = BALL_LOST;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0);
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    exp_t e;
    check("start_update", 32'(START_UPDATE), 32'(fs_prev));
    fs_prev = FRAME_START && RESET_N;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check($sformatf("valid(%0d,%0d)", e.x, e.y), 32'(COLOR_VALID), 32'(e.v));
      check($sformatf("color(%0d,%0d)", e.x, e.y), 32'(COLOR), 32'(e.c));
      if (e.v)
        $display("pixel (%0d,%0d) color=%02h expected=%02h", e.x, e.y, COLOR, e.c);
    end else begin
      check("idle_valid", 32'(COLOR_VALID), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;

    // Reset state: nothing visible, no START_UPDATE without FRAME_START.
    idle(6);

    // Frame 1: ball at (395,400), paddle at 370, all blocks present.
    BALL_X_PIXEL   = 10'd395;
    BALL_Y_PIXEL   = 10'd400;
    PADDLE_X_PIXEL = 10'd370;
    BLOCK_STATE    = '1;
    BALL_LOST      = 1'b0;
    drive(0, 0, 1'b0, 1'b1);
    drive(395, 400, 1'b1, 1'b0);
    drive(402, 407, 1'b1, 1'b0);
    drive(403, 400, 1'b1, 1'b0);
    drive(394, 400, 1'b1, 1'b0);
    drive(16, 64, 1'b1, 1'b0);
    drive(79, 64, 1'b1, 1'b0);
    drive(90, 100, 1'b1, 1'b0);
    drive(16, 63, 1'b1, 1'b0);
    drive(15, 64, 1'b1, 1'b0);
    drive(783, 159, 1'b1, 1'b0);
    drive(782, 158, 1'b1, 1'b0);
    drive(0, 0, 1'b1, 1'b0);
    drive(5, 300, 1'b1, 1'b0);
    drive(433, 560, 1'b1, 1'b0);
    drive(434, 560, 1'b1, 1'b0);
    drive(370, 567, 1'b1, 1'b0);
    drive(370, 568, 1'b1, 1'b0);
    drive(369, 560, 1'b1, 1'b0);
    drive(784, 300, 1'b1, 1'b0);
    drive(783, 300, 1'b1, 1'b0);
    drive(400, 15, 1'b1, 1'b0);
    drive(395, 400, 1'b0, 1'b0);

    // Clear block 25; the pixel sharing the FRAME_START cycle sees the old frame.
    BLOCK_STATE[25] = 1'b0;
    drive(90, 100, 1'b1, 1'b1);
    drive(90, 100, 1'b1, 1'b0);
    drive(91, 101, 1'b1, 1'b0);

    // Back-to-back frames; ball near the 10-bit limit must not wrap.
    BALL_X_PIXEL = 10'd1020;
    BALL_Y_PIXEL = 10'd1020;
    drive(0, 0, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b1);
    drive(1023, 1023, 1'b1, 1'b0);
    drive(3, 1023, 1'b1, 1'b0);

    // Ball overlapping the paddle.
    BALL_X_PIXEL = 10'd400;
    BALL_Y_PIXEL = 10'd562;
    drive(0, 0, 1'b0, 1'b1);
    drive(403, 565, 1'b1, 1'b0);
    drive(420, 565, 1'b1, 1'b0);

    // Live input changes without FRAME_START must not move the ball.
    BALL_X_PIXEL = 10'd100;
    drive(403, 565, 1'b1, 1'b0);
    drive(100, 565, 1'b1, 1'b0);

    // Ball lost tint on background, gap and absent-block pixels.
    BALL_LOST = 1'b1;
    drive(0, 0, 1'b0, 1'b1);
    drive(300, 300, 1'b1, 1'b0);
    drive(79, 64, 1'b1, 1'b0);
    drive(90, 100, 1'b1, 1'b0);
    drive(20, 70, 1'b1, 1'b0);
    drive(5, 300, 1'b1, 1'b0);

    // Reset mid-stream with wall pixels in flight.
    drive(5, 300, 1'b1, 1'b0);
    drive(5, 301, 1'b1, 1'b0);
    drive(5, 302, 1'b1, 1'b0);
    drive(5, 303, 1'b1, 1'b0);
    #2;
    RESET_N     = 1'b0;
    PIXEL_VALID = 1'b0;
    FRAME_START = 1'b0;
    sb.delete();
    m_pad  = 0;
    m_bx   = 0;
    m_by   = 0;
    m_blk  = '0;
    m_lost = 1'b0;
    fs_prev = 1'b0;
    #1;
    check("rst_color_valid", 32'(COLOR_VALID), 32'h0);
    check("rst_color", 32'(COLOR), 32'h0);
    check("rst_start_update", 32'(START_UPDATE), 32'h0);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;

    // After release: no stale pixels, cleared snapshot (ball and paddle at 0).
    idle(4);
    drive(5, 5, 1'b1, 1'b0);
    drive(300, 300, 1'b1, 1'b0);
    drive(30, 563, 1'b1, 1'b0);
    idle(6);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
